// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue between a one-cycle-latency
// instruction memory and decode; branch/jump redirects flush queue and in-flight fetch.
module if_prefetch_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  FIFO_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          branch_taken,
  input  logic [PC_WIDTH-1:0]           branch_addr,
  input  logic                          is_jump,
  input  logic [PC_WIDTH-1:0]           jump_addr,
  output logic                          imem_req,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic [INSTR_WIDTH-1:0]        imem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTR_WIDTH-1:0]        instruction,
  output logic [PC_WIDTH-1:0]           next_pc,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = INSTR_WIDTH + PC_WIDTH;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic                inflight;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;
  logic [CNT_W:0]      credit_used;
  logic                issue;
  logic                push;
  logic                pop;
  logic                head_valid;
  logic [ENTRY_W-1:0]  head_entry;

  // Branch wins over jump when both arrive together: it belongs to the older instruction.
  assign redirect        = branch_taken | is_jump;
  assign redirect_target = branch_taken ? branch_addr : jump_addr;

  // An in-flight fetch already owns a queue slot, so it counts against the credit.
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue       = rst && !redirect && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  assign head_valid = (count != '0);
  assign push       = rst && !redirect && inflight;
  assign pop        = rst && !redirect && head_valid && out_ready;
  assign head_entry = fifo_mem[rd_ptr];

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc;
  assign out_valid   = rst && head_valid;
  assign instruction = out_valid ? head_entry[ENTRY_W-1:PC_WIDTH] : '0;
  assign next_pc     = out_valid ? head_entry[PC_WIDTH-1:0] : '0;
  assign occupancy   = rst ? count : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(1);
        req_pc   <= fetch_pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Queue storage needs no reset; entries are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {imem_rdata, req_pc + PC_WIDTH'(1)};
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized bench for if_prefetch_stage checked against a queue-based
// reference model of fetch issue, response, pop and redirect rules.
module tb_if_prefetch_stage;

  localparam int PW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          branch_taken;
  logic [PW-1:0] branch_addr;
  logic          is_jump;
  logic [PW-1:0] jump_addr;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] instruction;
  logic [PW-1:0] next_pc;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .is_jump(is_jump), .jump_addr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .next_pc(next_pc), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [IW-1:0] ins;
    logic [PW-1:0] npc;
  } entry_t;

  entry_t        model_q[$];
  logic [PW-1:0] model_pc;
  bit            model_pend;
  logic [PW-1:0] model_pend_pc;
  bit            prev_req;
  logic [PW-1:0] prev_addr;
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [IW-1:0] memWord(input logic [PW-1:0] a);
    return a * 16 + (a >> 28);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input bit rst_v, input bit br, input logic [PW-1:0] baddr,
                               input bit jmp, input logic [PW-1:0] jaddr, input bit rdy);
    bit            redir;
    bit            exp_req;
    bit            exp_valid;
    bit            do_pop;
    entry_t        head;
    logic [PW-1:0] tgt;
    rst          = rst_v;
    branch_taken = br;
    branch_addr  = baddr;
    is_jump      = jmp;
    jump_addr    = jaddr;
    out_ready    = rdy;
    imem_rdata   = prev_req ? memWord(prev_addr) : IW'($urandom);
    @(negedge clk);
    redir     = br || jmp;
    exp_req   = rst_v && !redir && (model_q.size() + (model_pend ? 1 : 0) < DEPTH);
    exp_valid = rst_v && (model_q.size() > 0);
    head      = exp_valid ? model_q[0] : '0;
    checkOutput("imem_req", 64'(imem_req), 64'(exp_req));
    checkOutput("imem_addr", 64'(imem_addr), 64'(model_pc));
    checkOutput("occupancy", 64'(occupancy), rst_v ? 64'(model_q.size()) : 64'd0);
    checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
    checkOutput("instruction", 64'(instruction), 64'(head.ins));
    checkOutput("next_pc", 64'(next_pc), 64'(head.npc));
    prev_req  = imem_req;
    prev_addr = imem_addr;
    if (!rst_v) begin
      model_q.delete();
      model_pc   = '0;
      model_pend = 0;
    end else if (redir) begin
      tgt = br ? baddr : jaddr;
      model_q.delete();
      model_pc   = tgt;
      model_pend = 0;
    end else begin
      do_pop = exp_valid && rdy;
      if (do_pop) void'(model_q.pop_front());
      if (model_pend) model_q.push_back('{ins: memWord(model_pend_pc), npc: model_pend_pc + 1});
      model_pend = exp_req;
      if (exp_req) begin
        model_pend_pc = model_pc;
        model_pc      = model_pc + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, '0, 0, '0, rdy);
  endtask

  initial begin
    rst = 0; branch_taken = 0; branch_addr = '0; is_jump = 0; jump_addr = '0;
    out_ready = 0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_pc = '0; model_pend = 0; model_pend_pc = '0; prev_req = 0; prev_addr = '0;

    applyStimulus(0, 0, '0, 0, '0, 1);
    runCycles(8, 1);
    // Back-pressure until the queue saturates, then drain.
    runCycles(10, 0);
    runCycles(6, 1);
    applyStimulus(1, 1, 32'd100, 0, '0, 1);
    runCycles(5, 1);
    applyStimulus(1, 1, 32'd40, 1, 32'd80, 1);
    runCycles(5, 1);
    applyStimulus(1, 0, '0, 1, 32'd200, 0);
    runCycles(4, 0);
    runCycles(3, 1);
    // Wrap-around through the all-ones address.
    applyStimulus(1, 1, 32'hFFFF_FFFE, 0, '0, 1);
    runCycles(7, 1);
    // Reset while the queue is nearly full with a fetch outstanding.
    runCycles(3, 0);
    applyStimulus(0, 0, '0, 0, '0, 0);
    runCycles(5, 1);

    for (int i = 0; i < 600; i++) begin
      bit            r;
      bit            b;
      bit            j;
      logic [PW-1:0] ba;
      logic [PW-1:0] ja;
      r  = ($urandom_range(0, 49) != 0);
      b  = ($urandom_range(0, 15) == 0);
      j  = ($urandom_range(0, 15) == 0);
      ba = $urandom_range(0, 1) ? PW'($urandom) : PW'(32'hFFFF_FFFC + $urandom_range(0, 3));
      ja = PW'($urandom);
      applyStimulus(r, b, ba, j, ja, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
